// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - Opcodes, ALU/mux encodings, state enum and control-word layout
// Shared by the multicycle control FSM and its output decoder.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALUOp codes, consumed by the ALU function decoder
  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    ADDR_CALC = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    LUI_EXEC  = 4'd11,
    IMM_WB    = 4'd12,
    TRAP      = 4'd13
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_not;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_out_t;

  localparam int CTRL_W = $bits(ctrl_out_t);

  function automatic logic is_bne(input logic [5:0] op);
    return op == OP_BNE;
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// rtl/ctrl_out_decode.sv - Combinational state-to-control-word decode for the multicycle FSM
// TRAP decode is present only when MULTICYCLE_CTRL_TRAP_EN is defined.
module ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic              is_bne_i,
  input  logic              fetch_done_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  state_e    st;
  ctrl_out_t c;

  assign st = state_e'(state_i);

  always_comb begin
    c = '0;
    case (st)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        // IR load and PC+4 commit only on the cycle the fetch completes
        c.ir_write  = fetch_done_i;
        c.pc_write  = fetch_done_i;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM_SHL;
        c.alu_op    = ALUOP_ADD;
      end
      ADDR_CALC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_RTYPE;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALUOP_SUB;
        c.pc_source     = PCSRC_ALUOUT;
        c.pc_write_cond = ~is_bne_i;
        c.pc_write_not  = is_bne_i;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      LUI_EXEC: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_LUI;
      end
      IMM_WB: begin
        c.reg_write = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      TRAP: begin
        c.illegal_op = 1'b1;
      end
`endif
      default: begin
        c = '0;
      end
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Multi-cycle main control FSM (fetch/decode/execute/mem/writeback)
// Define MULTICYCLE_CTRL_TRAP_EN to trap unknown opcodes; otherwise they retire as NOPs.
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_not,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic              fetch_done;
  logic [CTRL_W-1:0] ctrl_vec;
  ctrl_out_t         ctrl;
  logic              unused_zero;

  // zero only gates the PC write outside this block
  assign unused_zero = zero;

  // a completion arriving while reset is asserted must not load IR or PC
  assign fetch_done = (state_q == FETCH) && mem_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (mem_ready) state_d = DECODE;
      DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW, OP_ADDI: state_d = ADDR_CALC;
          OP_RTYPE:              state_d = R_EXEC;
          OP_BEQ, OP_BNE:        state_d = BRANCH;
          OP_J:                  state_d = JUMP;
          OP_LUI:                state_d = LUI_EXEC;
          default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            state_d = TRAP;
`else
            state_d = FETCH;
`endif
          end
        endcase
      end
      // later states steer on the opcode latched in DECODE, not the live IR
      ADDR_CALC: begin
        case (op_q)
          OP_LW:   state_d = MEM_READ;
          OP_SW:   state_d = MEM_WRITE;
          default: state_d = IMM_WB;
        endcase
      end
      MEM_READ:  if (mem_ready) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (mem_ready) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      LUI_EXEC:  state_d = IMM_WB;
      IMM_WB:    state_d = FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      TRAP:      state_d = TRAP;
`endif
      default:   state_d = IDLE;
    endcase
  end

  ctrl_out_decode u_decode (
    .state_i      (state_q),
    .is_bne_i     (is_bne(op_q)),
    .fetch_done_i (fetch_done),
    .ctrl_o       (ctrl_vec)
  );

  assign ctrl          = ctrl_out_t'(ctrl_vec);
  assign alu_op        = ctrl.alu_op;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_write_not  = ctrl.pc_write_not;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - Self-checking bench for multicycle_control
// Honours MULTICYCLE_CTRL_TRAP_EN for the unknown-opcode scenarios.
module tb_multicycle_control;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LUI = 6'h0F, OP_J = 6'h02;

  // expected-word layout: {alu_op, pcw, pcc, pcn, iod, mr, mw, irw, rd, m2r, rw, sa, srcb, pcsrc, ill}
  localparam logic [17:0] F_PCW = 18'h08000, F_PCC = 18'h04000, F_PCN = 18'h02000;
  localparam logic [17:0] F_IOD = 18'h01000, F_MR = 18'h00800, F_MW = 18'h00400;
  localparam logic [17:0] F_IRW = 18'h00200, F_RD = 18'h00100, F_M2R = 18'h00080;
  localparam logic [17:0] F_RW = 18'h00040, F_SA = 18'h00020, F_ILL = 18'h00001;
  localparam logic [17:0] AOP_R = 18'h00000, AOP_SUB = 18'h10000, AOP_ADD = 18'h20000, AOP_LUI = 18'h30000;
  localparam logic [17:0] SB_RT = 18'h0, SB_4 = 18'h8, SB_IMM = 18'h10, SB_SH = 18'h18;
  localparam logic [17:0] PS_ALU = 18'h0, PS_OUT = 18'h2, PS_J = 18'h4;

  localparam logic [17:0] W_FETCH = F_MR | AOP_ADD | SB_4 | PS_ALU;
  localparam logic [17:0] W_DEC   = AOP_ADD | SB_SH;
  localparam logic [17:0] W_ADDR  = F_SA | SB_IMM | AOP_ADD;
  localparam logic [17:0] W_MRD   = F_MR | F_IOD;
  localparam logic [17:0] W_MWB   = F_RW | F_M2R;
  localparam logic [17:0] W_MWR   = F_MW | F_IOD;
  localparam logic [17:0] W_REX   = F_SA | SB_RT | AOP_R;
  localparam logic [17:0] W_RWB   = F_RW | F_RD;
  localparam logic [17:0] W_BR    = F_SA | SB_RT | AOP_SUB | PS_OUT;
  localparam logic [17:0] W_J     = F_PCW | PS_J;
  localparam logic [17:0] W_LUI   = SB_IMM | AOP_LUI;
  localparam logic [17:0] W_IWB   = F_RW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic       pc_write, pc_write_cond, pc_write_not, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [3:0] state_dbg;
  logic [17:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [17:0] w; int rdy; int st; } step_t;
  step_t exp_q[$];
  logic [5:0] legal [8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_LUI, OP_J};

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_write_not(pc_write_not), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  assign obs = {alu_op, pc_write, pc_write_cond, pc_write_not, i_or_d, mem_read, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, illegal_op};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal[k]) if (legal[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_step(input logic [17:0] w, input int rdy, input int st);
    step_t s;
    s.w = w; s.rdy = rdy; s.st = st;
    exp_q.push_back(s);
  endtask

  // rdy: 0/1 = mem_ready driven to that value, 2 = don't care (randomised); st = -1 skips state check
  task automatic build_model(input logic [5:0] op, input int fw, input int mw);
    exp_q.delete();
    for (int i = 0; i < fw; i++) push_step(W_FETCH, 0, 1);
    push_step(W_FETCH | F_IRW | F_PCW, 1, 1);
    push_step(W_DEC, 2, 2);
    case (op)
      OP_LW: begin
        push_step(W_ADDR, 2, -1);
        for (int i = 0; i < mw; i++) push_step(W_MRD, 0, -1);
        push_step(W_MRD, 1, -1);
        push_step(W_MWB, 2, -1);
      end
      OP_SW: begin
        push_step(W_ADDR, 2, -1);
        for (int i = 0; i < mw; i++) push_step(W_MWR, 0, -1);
        push_step(W_MWR, 1, -1);
      end
      OP_ADDI: begin push_step(W_ADDR, 2, -1); push_step(W_IWB, 2, -1); end
      OP_R:    begin push_step(W_REX, 2, -1);  push_step(W_RWB, 2, -1); end
      OP_BEQ:  push_step(W_BR | F_PCC, 2, -1);
      OP_BNE:  push_step(W_BR | F_PCN, 2, -1);
      OP_J:    push_step(W_J, 2, -1);
      OP_LUI:  begin push_step(W_LUI, 2, -1); push_step(W_IWB, 2, -1); end
      default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        for (int i = 0; i < 5; i++) push_step(F_ILL, 2, 13);
`endif
      end
    endcase
  endtask

  task automatic exec_steps(input string tag, input logic [5:0] op, input int limit);
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      mem_ready = (exp_q[i].rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(exp_q[i].rdy);
      opcode    = (exp_q[i].st == 2) ? op : 6'($urandom_range(0, 63));
      zero      = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_q[i].w) begin
        n_err++;
        $display("FAIL %s op=%h cycle %0d: outputs got %h expected %h", tag, op, i, obs, exp_q[i].w);
      end
      if (exp_q[i].st >= 0) begin
        n_cmp++;
        if (state_dbg !== 4'(exp_q[i].st)) begin
          n_err++;
          $display("FAIL %s op=%h cycle %0d: state_dbg got %0d expected %0d", tag, op, i, state_dbg, exp_q[i].st);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int mw);
    build_model(op, fw, mw);
    exec_steps(tag, op, 1000);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    n_cmp++;
    if (obs !== 18'h0 || state_dbg !== 4'd0) begin
      n_err++;
      $display("FAIL %s: outputs %h state %0d, expected 00000 state 0", tag, obs, state_dbg);
    end
  endtask

  // enters and leaves just after a rising edge; leaves the DUT in FETCH
  task automatic apply_reset();
    reset = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check_idle("reset_held");
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("reset_released_idle");
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs !== W_FETCH || state_dbg !== 4'd1) begin
        n_err++;
        $display("FAIL fetch_after_reset: outputs %h state %0d, expected %h state 1", obs, state_dbg, W_FETCH);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rformat();
    run_instr("rformat", OP_R, 0, 0);
    run_instr("rformat_fetch_wait", OP_R, 2, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", OP_LW, 0, 3);
  endtask

  task automatic test_bne();
    run_instr("bne", OP_BNE, 0, 0);
    run_instr("beq", OP_BEQ, 1, 0);
  endtask

  task automatic test_lui();
    run_instr("lui", OP_LUI, 0, 0);
  endtask

  task automatic test_reset_mid_access();
    build_model(OP_LW, 0, 2);
    exec_steps("lw_pre_reset", OP_LW, 3);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== W_MRD) begin
      n_err++;
      $display("FAIL reset_in_mem_read: outputs got %h expected %h", obs, W_MRD);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("mem_read_dropped");
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== W_FETCH || state_dbg !== 4'd1) begin
      n_err++;
      $display("FAIL reset_in_fetch: outputs %h state %0d, expected %h state 1", obs, state_dbg, W_FETCH);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("fetch_dropped");
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'h3F;
        for (int k = 0; k < 20 && is_legal(op); k++) op = 6'($urandom_range(0, 63));
        if (is_legal(op)) op = 6'h3F;
      end else begin
        op = legal[$urandom_range(0, 7)];
      end
      run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3));
`ifdef MULTICYCLE_CTRL_TRAP_EN
      if (!is_legal(op)) apply_reset();
`endif
    end
  endtask

  task automatic test_illegal();
    run_instr("illegal_3f", 6'h3F, 0, 0);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    apply_reset();
`endif
  endtask

  task automatic test_final_fetch();
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== W_FETCH || state_dbg !== 4'd1) begin
      n_err++;
      $display("FAIL final_fetch: outputs %h state %0d, expected %h state 1", obs, state_dbg, W_FETCH);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_rformat();
    test_lw_wait();
    test_bne();
    test_lui();
    test_reset_mid_access();
    run_instr("sw", OP_SW, 0, 1);
    run_instr("j", OP_J, 0, 0);
    run_instr("addi", OP_ADDI, 0, 0);
    test_random();
    test_illegal();
    test_final_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
